// File: rtl/muldiv_ctrl_if.sv
// Execute-stage handshake and HI/LO result bus for the multiply/divide unit.
interface muldiv_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, stall, done, rdata, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, stall, done, rdata, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, 34-cycle latency.
module muldiv_ctrl (
  input  logic         clk,
  input  logic         rst,
  muldiv_ctrl_if.slave bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W-1:0]   a_raw_q, a_raw_d;
  logic           neg_res_q, neg_res_d;
  logic           neg_rem_q, neg_rem_d;
  logic           is_div_q, is_div_d;
  logic           dz_q, dz_d;
  logic           fix2_q, fix2_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           op_mul, op_div, op_signed;
  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     mul_sum;
  logic [W:0]     trial;
  logic           fits;
  logic [W-1:0]   sub;

  // Datapath helpers: operand magnitudes and one iteration step of each algorithm.
  always_comb begin
    op_mul    = (bus.op[2:1] == 2'b00);
    op_div    = (bus.op[2:1] == 2'b01);
    op_signed = bus.op[0];
    mag_a     = (op_signed && bus.a[W-1]) ? W'(-bus.a) : bus.a;
    mag_b     = (op_signed && bus.b[W-1]) ? W'(-bus.b) : bus.b;
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    trial     = {acc_q[2*W-1:W], acc_q[W-1]};
    fits      = (trial >= {1'b0, opb_q});
    sub       = trial[W-1:0] - opb_q;
  end

  // Next-state and register updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    a_raw_d   = a_raw_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    fix2_d    = fix2_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (op_mul || op_div) begin
            state_d   = op_mul ? MUL : DIV;
            cnt_d     = '0;
            fix2_d    = 1'b0;
            opb_d     = op_mul ? mag_a : mag_b;
            acc_d     = {W'(0), (op_mul ? mag_b : mag_a)};
            neg_res_d = op_signed && (bus.a[W-1] ^ bus.b[W-1]);
            neg_rem_d = op_signed && bus.a[W-1];
            is_div_d  = op_div;
            dz_d      = op_div && (bus.b == '0);
            a_raw_d   = bus.a;
          end else if (bus.op == 3'b110) begin
            hi_d = bus.a;
          end else if (bus.op == 3'b111) begin
            lo_d = bus.a;
          end
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[W-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) state_d = FIX;
      end
      DIV: begin
        acc_d = fits ? {sub, acc_q[W-2:0], 1'b1} : {trial[W-1:0], acc_q[W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) state_d = FIX;
      end
      FIX: begin
        // First cycle applies the sign correction, second commits HI/LO.
        if (!fix2_q) begin
          fix2_d = 1'b1;
          if (!is_div_q) begin
            acc_d = neg_res_q ? -acc_q : acc_q;
          end else if (dz_q) begin
            acc_d = {a_raw_q, {W{1'b1}}};
          end else begin
            acc_d = {(neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W]),
                     (neg_res_q ? -acc_q[W-1:0]   : acc_q[W-1:0])};
          end
        end else begin
          fix2_d  = 1'b0;
          hi_d    = acc_q[2*W-1:W];
          lo_d    = acc_q[W-1:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      a_raw_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      fix2_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      a_raw_q   <= a_raw_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      dz_q      <= dz_d;
      fix2_q    <= fix2_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.stall = bus.start & busy_q;
  assign bus.rdata = (bus.op == 3'b100) ? hi_q : lo_q;
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  operation request from the execute stage, qualifies op/a/b.
REQ-005 op  input  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MFHI, 101 MFLO, 110 MTHI, 111 MTLO.
REQ-006 a  input  32  multiplicand, dividend, or MTHI/MTLO source.
REQ-007 b  input  32  multiplier or divisor.
REQ-008 busy  output  1  high while a mul/div iteration is in progress.
REQ-009 stall  output  1  pipeline hold request, combinational.
REQ-010 done  output  1  one-cycle pulse; new HI/LO are visible.
REQ-011 rdata  output  32  MFHI/MFLO read data, combinational.
REQ-012 hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-013 The FSM SHALL have the states IDLE, MUL, DIV and FIX.
REQ-014 IDLE with start and op in {000,001} SHALL latch the operands and go to MUL with iteration count 0.
REQ-015 IDLE with start and op in {010,011} SHALL latch the operands and go to DIV with iteration count 0.
REQ-016 MUL SHALL be a 32-step shift-add on operand magnitudes, one bit per cycle.
REQ-017 DIV SHALL be a 32-step restoring divide on operand magnitudes, one bit per cycle.
REQ-018 After count 31, MUL/DIV SHALL go to FIX.
REQ-019 FIX SHALL apply signed correction, write HI/LO and return to IDLE.
REQ-020 Signed correction: product negated if the operand signs differ; quotient negated if the operand signs differ; remainder takes the sign of the dividend.
REQ-021 MULT/MULTU: HI = product[63:32], LO = product[31:0].
REQ-022 DIV/DIVU: LO = quotient, HI = remainder.
REQ-023 Latency: with the start edge at E0, HI/LO SHALL update at edge E34 and done SHALL be high for exactly the cycle following E34.
REQ-024 busy SHALL be high from the cycle after E0 through the cycle ending at E34, and low during the done cycle.
REQ-025 Divide by zero (DIV or DIVU) SHALL give LO = 0xFFFFFFFF and HI = a, with normal 34-cycle latency.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0x00000000, with no exception.
REQ-027 MTHI/MTLO in IDLE SHALL write a into hi/lo at the next edge, with no busy and no done.
REQ-028 rdata SHALL equal hi when op = 100 and lo otherwise; it is valid whenever stall = 0.
REQ-029 stall SHALL equal start AND busy, for any op.
REQ-030 Any start while busy SHALL be ignored, with no state change; the pipeline holds and reissues it.
REQ-031 MFHI/MFLO/MTHI/MTLO issued in the done cycle SHALL proceed without stall and see or overwrite the new HI/LO.
REQ-032 A new mul/div start in the done cycle SHALL be accepted, with E0 at that cycle's edge.
REQ-033 op values outside the mul/div/move set do not exist; all eight encodings are defined.

Reset
REQ-034 rst high at an edge SHALL force: state IDLE, count 0, hi = lo = 0, busy = 0, done = 0.
REQ-035 rst SHALL take priority over start and over any in-progress operation.
REQ-036 Reset mid-operation SHALL discard the operation: no HI/LO write and no done pulse.
REQ-037 stall SHALL be 0 in the cycle after reset.

Verification
REQ-038 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at E34+1 for one cycle; HI=0xFFFFFFFE, LO=0x00000001; busy high for exactly 34 cycles.
REQ-039 MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-040 DIVU a=7, b=0 -> LO=0xFFFFFFFF, HI=0x00000007; DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-041 DIVU a=100, b=7 with MFHI held asserted from 5 cycles after start -> stall=1 every cycle until the done cycle, stall=0 in the done cycle, rdata=0x00000002; a second MULTU start during busy is ignored (HI/LO unchanged by it).
REQ-042 MULT started, rst pulsed at iteration 10 -> next cycle busy=0, hi=lo=0, no done within 40 cycles; then MTLO a=0x00001234 -> lo=0x00001234 one edge later, hi=0.
REQ-043 Back-to-back: MULTU 3*5 then DIVU 15/4 issued in the done cycle -> first HI/LO=0/15, second done 35 cycles later with LO=3, HI=3.
